// File: rtl/sample_collector.sv
// Scans enabled pin-controller channels, validates each returned sample word and
// queues samples whose count has changed into a timestamped show-ahead FIFO.
module sample_collector #(
    parameter int NUM_CHANNELS = 16,
    parameter int FIFO_DEPTH   = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          run,
    input  logic                          clear,
    input  logic [NUM_CHANNELS-1:0]       channel_mask,
    input  logic [31:0]                   current_time,
    output logic                          output_sample,
    output logic [7:0]                    channel_select,
    input  logic [31:0]                   sample_data,
    input  logic                          fifo_rd,
    output logic [63:0]                   fifo_data,
    output logic                          fifo_empty,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [15:0]                   error_count
);

    localparam int PTR_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        STROBE  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic [PTR_W-1:0]   ptr_reg;
    logic [PTR_W-1:0]   ptr_next;
    logic [PTR_W-1:0]   ptr_inc;

    // ------------------------------------------------------------------
    // Channel scan FSM
    // ------------------------------------------------------------------
    assign ptr_inc = (ptr_reg == PTR_W'(NUM_CHANNELS - 1)) ? '0 : ptr_reg + PTR_W'(1);

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            SCAN: begin
                if (run) begin
                    if (channel_mask[ptr_reg]) begin
                        state_next = STROBE;
                    end else begin
                        ptr_next = ptr_inc;
                    end
                end
            end
            STROBE: begin
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = SCAN;
                ptr_next   = ptr_inc;
            end
            default: begin
                state_next = SCAN;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= SCAN;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Decoded from state so an asynchronous reset drops the strobe immediately.
    assign output_sample  = (state_reg == STROBE);
    assign channel_select = 8'(ptr_reg);

    // ------------------------------------------------------------------
    // Capture decode and new-sample detection
    // ------------------------------------------------------------------
    logic               capture;
    logic               marker_ok;
    logic [15:0]        cap_cnt;
    logic               cap_bit;
    logic               is_new;
    logic               push_req;
    logic [63:0]        push_word;
    logic [15:0]        last_cnt_mem [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] seen_valid_reg;

    assign capture   = (state_reg == CAPTURE);
    assign marker_ok = (sample_data[15:1] == {12'hABC, 3'b111});
    assign cap_cnt   = sample_data[31:16];
    assign cap_bit   = sample_data[0];
    assign is_new    = !seen_valid_reg[ptr_reg] || (last_cnt_mem[ptr_reg] != cap_cnt);
    assign push_req  = capture && marker_ok && is_new;
    assign push_word = {current_time, channel_select, cap_cnt, 7'b0, cap_bit};

    // Last count is only meaningful while the matching seen bit is set, so it needs no reset.
    always_ff @(posedge clk) begin
        if (capture && marker_ok) begin
            last_cnt_mem[ptr_reg] <= cap_cnt;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_seen
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    seen_valid_reg[gi] <= 1'b0;
                end else if (clear) begin
                    seen_valid_reg[gi] <= 1'b0;
                end else if (capture && marker_ok && (ptr_reg == PTR_W'(gi))) begin
                    seen_valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    logic [15:0] error_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_count_reg <= '0;
        end else if (clear) begin
            error_count_reg <= '0;
        end else if (capture && !marker_ok && (error_count_reg != 16'hFFFF)) begin
            error_count_reg <= error_count_reg + 16'd1;
        end
    end

    assign error_count = error_count_reg;

    // ------------------------------------------------------------------
    // Timestamped FIFO with a registered show-ahead head word
    // ------------------------------------------------------------------
    logic [63:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [AW-1:0]  rd_ptr_next;
    logic [CW-1:0]  count_reg;
    logic [CW-1:0]  count_next;
    logic [63:0]    head_reg;
    logic           overflow_reg;
    logic           full;
    logic           pop_en;
    logic           push_en;
    logic           drop;

    assign full    = (count_reg == CW'(FIFO_DEPTH));
    assign pop_en  = fifo_rd && (count_reg != '0);
    assign push_en = push_req && (!full || pop_en);
    assign drop    = push_req && full && !pop_en;

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (clear) begin
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (pop_en) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_en && !clear) begin
            fifo_mem[wr_ptr_reg] <= push_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (clear) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // The word being written this cycle can only be the next head when it lands in a
    // queue that ends up holding exactly that entry, so forward it past the RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_reg <= '0;
        end else if (clear || (count_next == '0)) begin
            head_reg <= '0;
        end else if (push_en && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= push_word;
        end else begin
            head_reg <= fifo_mem[rd_ptr_next];
        end
    end

    assign fifo_data  = head_reg;
    assign fifo_count = count_reg;
    assign fifo_empty = (count_reg == '0);
    assign fifo_full  = full;
    assign overflow   = overflow_reg;

endmodule

// File: tb/tb_sample_collector.sv
// Directed bench for sample_collector: a behavioural pin-controller responder answers
// each strobe, and every observation is checked against hand-derived values.
module tb_sample_collector;

    localparam int NCH   = 16;
    localparam int DEPTH = 4;
    localparam logic [15:0] INC_BASE = 16'h0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic        clear;
    logic [15:0] channel_mask;
    logic [31:0] current_time;
    logic        output_sample;
    logic [7:0]  channel_select;
    logic [31:0] sample_data = 32'h0;
    logic        fifo_rd;
    logic [63:0] fifo_data;
    logic        fifo_empty;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic [15:0] error_count;

    logic [31:0] cyc = 32'h0;
    logic [31:0] resp [NCH];
    logic        inc_mode;
    logic [15:0] inc_k = 16'h0;

    int checks   = 0;
    int failures = 0;

    sample_collector #(
        .NUM_CHANNELS (NCH),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .run            (run),
        .clear          (clear),
        .channel_mask   (channel_mask),
        .current_time   (current_time),
        .output_sample  (output_sample),
        .channel_select (channel_select),
        .sample_data    (sample_data),
        .fifo_rd        (fifo_rd),
        .fifo_data      (fifo_data),
        .fifo_empty     (fifo_empty),
        .fifo_full      (fifo_full),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .error_count    (error_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 32'd1;
    assign current_time = cyc;

    // Pin-controller model: answers a strobe with data valid during the following cycle.
    always @(posedge clk) begin
        if (!inc_mode) inc_k <= 16'h0;
        if (output_sample) begin
            if (inc_mode && channel_select == 8'd0) begin
                sample_data <= {INC_BASE + inc_k, 16'hABCF};
                inc_k       <= inc_k + 16'd1;
            end else begin
                sample_data <= resp[channel_select[3:0]];
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h", tag, obs);
    endtask

    task automatic wait_chan(input int target, output logic [31:0] t);
        bit found = 1'b0;
        t = 32'h0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (output_sample && channel_select == 8'(target)) begin
                found = 1'b1;
                t = current_time;
            end
        end
        checks++;
        assert (found) else begin
            failures++;
            $error("FAIL strobe_wait observed=none expected=chan %0d", target);
        end
    endtask

    task automatic wait_any(output logic [7:0] ch, output logic [31:0] t);
        bit found = 1'b0;
        ch = 8'h0;
        t  = 32'h0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (output_sample) begin
                found = 1'b1;
                ch = channel_select;
                t  = current_time;
            end
        end
        checks++;
        assert (found) else begin
            failures++;
            $error("FAIL strobe_wait_any observed=none expected=strobe");
        end
    endtask

    task automatic pop();
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
    endtask

    task automatic two_cycles();
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [7:0]  ch;
        logic [31:0] ta;
        logic [31:0] tb;
        logic [31:0] t;
        int          ns;

        reset = 1'b1; run = 1'b0; clear = 1'b0; fifo_rd = 1'b0;
        channel_mask = 16'h0; inc_mode = 1'b0;
        for (int i = 0; i < NCH; i++) resp[i] = 32'h0;
        repeat (3) @(negedge clk);

        check("rst_strobe",  64'(output_sample), 64'(0));
        check("rst_chsel",   64'(channel_select), 64'(0));
        check("rst_empty",   64'(fifo_empty), 64'(1));
        check("rst_full",    64'(fifo_full), 64'(0));
        check("rst_count",   64'(fifo_count), 64'(0));
        check("rst_data",    fifo_data, 64'(0));
        check("rst_ovf",     64'(overflow), 64'(0));
        check("rst_err",     64'(error_count), 64'(0));

        // Empty mask: scanning never strobes.
        reset = 1'b0; run = 1'b1;
        ns = 0;
        repeat (20) begin @(negedge clk); if (output_sample) ns++; end
        check("mask0_no_strobe", 64'(ns), 64'(0));

        // Test 1: two enabled channels, two entries in order.
        resp[0] = 32'h0001ABCF; resp[2] = 32'h0001ABCE;
        channel_mask = 16'h0005;
        wait_any(ch, ta);
        check("t1_first_chan", 64'(ch), 64'(0));
        @(negedge clk);
        check("t1_capture_strobe_low", 64'(output_sample), 64'(0));
        wait_any(ch, tb);
        check("t1_second_chan", 64'(ch), 64'(2));
        two_cycles();
        check("t1_count", 64'(fifo_count), 64'(2));
        check("t1_entry0", fifo_data, {ta + 32'd1, 8'h00, 16'h0001, 8'h01});
        pop();
        check("t1_entry1", fifo_data, {tb + 32'd1, 8'h02, 16'h0001, 8'h00});
        pop();
        check("t1_empty", 64'(fifo_empty), 64'(1));

        // Test 2: repeated count is discarded, a changed count is pushed once.
        repeat (5) wait_chan(0, t);
        @(negedge clk);
        resp[0] = 32'h0002ABCF;
        wait_chan(0, t);
        two_cycles();
        check("t2_count", 64'(fifo_count), 64'(1));
        check("t2_entry", fifo_data, {t + 32'd1, 8'h00, 16'h0002, 8'h01});
        pop();
        wait_chan(0, t);
        two_cycles();
        check("t2_no_repeat", 64'(fifo_count), 64'(0));

        // Test 3: malformed word on channel 1 counts errors, never pushes.
        channel_mask = 16'h0007;
        wait_chan(1, t);
        two_cycles();
        check("t3_err1", 64'(error_count), 64'(1));
        wait_chan(1, t);
        two_cycles();
        check("t3_err2", 64'(error_count), 64'(2));
        check("t3_no_push", 64'(fifo_count), 64'(0));

        run = 1'b0;
        repeat (4) @(negedge clk);

        // Test 4: fill, overflow, then simultaneous pop and push while full.
        channel_mask = 16'h0001; inc_mode = 1'b1; run = 1'b1;
        repeat (DEPTH) wait_chan(0, t);
        two_cycles();
        check("t4_count_full", 64'(fifo_count), 64'(DEPTH));
        check("t4_full", 64'(fifo_full), 64'(1));
        check("t4_no_ovf_yet", 64'(overflow), 64'(0));
        wait_chan(0, t);
        two_cycles();
        check("t4_ovf", 64'(overflow), 64'(1));
        check("t4_count_after_drop", 64'(fifo_count), 64'(DEPTH));
        check("t4_head_cnt", 64'(fifo_data[23:8]), 64'(16'h0100));
        wait_chan(0, t);
        @(negedge clk);
        fifo_rd = 1'b1;
        @(negedge clk);
        fifo_rd = 1'b0;
        check("t4_count_poppush", 64'(fifo_count), 64'(DEPTH));
        check("t4_full_poppush", 64'(fifo_full), 64'(1));
        check("t4_head_after_pop", 64'(fifo_data[23:8]), 64'(16'h0101));
        check("t4_ovf_sticky", 64'(overflow), 64'(1));

        // Test 6: clear beats a same-cycle push and pop, and forgets seen counts.
        wait_chan(0, t);
        @(negedge clk);
        clear = 1'b1; fifo_rd = 1'b1; inc_mode = 1'b0; resp[0] = 32'h0106ABCF;
        @(negedge clk);
        clear = 1'b0; fifo_rd = 1'b0;
        check("t6_empty", 64'(fifo_empty), 64'(1));
        check("t6_count", 64'(fifo_count), 64'(0));
        check("t6_ovf", 64'(overflow), 64'(0));
        check("t6_err", 64'(error_count), 64'(0));
        wait_chan(0, t);
        two_cycles();
        check("t6_repush_count", 64'(fifo_count), 64'(1));
        check("t6_repush_entry", fifo_data, {t + 32'd1, 8'h00, 16'h0106, 8'h01});
        wait_chan(0, t);
        two_cycles();
        check("t6_dup_discard", 64'(fifo_count), 64'(1));

        // Test 5: asynchronous reset in STROBE and in CAPTURE, then run dropped in STROBE.
        wait_chan(0, t);
        reset = 1'b1;
        #1;
        check("t5_rst_strobe_low", 64'(output_sample), 64'(0));
        check("t5_rst_count", 64'(fifo_count), 64'(0));
        check("t5_rst_chsel", 64'(channel_select), 64'(0));
        @(negedge clk);
        reset = 1'b0; resp[0] = 32'h0007ABCE;
        wait_chan(0, t);
        two_cycles();
        check("t5_after_rst_push", 64'(fifo_count), 64'(1));
        wait_chan(0, t);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_rst_cap_count", 64'(fifo_count), 64'(0));
        check("t5_rst_cap_strobe", 64'(output_sample), 64'(0));
        check("t5_rst_cap_data", fifo_data, 64'(0));
        @(negedge clk);
        reset = 1'b0;
        wait_chan(0, t);
        run = 1'b0;
        two_cycles();
        check("t5_run_drop_count", 64'(fifo_count), 64'(1));
        check("t5_run_drop_entry", fifo_data, {t + 32'd1, 8'h00, 16'h0007, 8'h00});
        ns = 0;
        repeat (20) begin @(negedge clk); if (output_sample) ns++; end
        check("t5_no_more_strobes", 64'(ns), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
